cp0_exc_unit: RTL and testbench
===============================

// Module: cp0_exc_unit
// PURPOSE
//  Parametrised CP0 exception/interrupt unit; successor to the plain latched cause register.
//  Holds Status, Cause, EPC and BadVAddr, prioritises N synchronous exception sources
//  and the HW interrupts, and issues a one-cycle pipeline flush with a redirect PC.
//  Serves ERET and mtc0/mfc0 access. Sits beside the MEM stage of the pipelined CPU.
// PARAMETERS
//  NUM_EXC  8             number of synchronous exception sources; index 0 = highest priority
//  NUM_HW   6             number of hardware interrupt lines, mapped to Cause.IP[NUM_HW+1:2]
//  EXC_VEC  32'hBFC00380  exception handler entry PC
// PORTS
//  clk        in   1          clock
//  reset      in   1          synchronous, active-low reset
//  exc_req    in   NUM_EXC    per-source exception request, valid for the instruction in MEM
//  exc_code   in   5*NUM_EXC  ExcCode per source; slice i = [5i+4:5i]
//  exc_pc     in   32         PC of the faulting instruction
//  exc_bd     in   1          faulting instruction sits in a branch delay slot
//  exc_badva  in   32         faulting address, for AdEL/AdES
//  hw_int     in   NUM_HW     level-sensitive external interrupts
//  eret       in   1          ERET is in MEM
//  mtc0_we    in   1          CP0 write enable
//  cp0_addr   in   5          CP0 register number for read/write
//  cp0_wdata  in   32         mtc0 data
//  cp0_rdata  out  32         combinational mfc0 read data; 0 for unimplemented registers
//  flush      out  1          registered one-cycle pipeline flush
//  flush_pc   out  32         redirect PC, valid while flush=1
//  exl        out  1          Status.EXL
// BEHAVIOUR
//  Reset (reset==0 at posedge): Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0,
//    BadVAddr=0, flush=0, flush_pc=0.
//  Interrupt take:
//    Condition: Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
//    ExcCode=0; takes priority over all exc_req bits.
//  Synchronous exception: lowest set index of exc_req wins; its exc_code is used.
//  On take, at the next edge:
//    ExcCode updated.
//    If EXL was 0: EPC = exc_bd ? exc_pc-4 : exc_pc; Cause.BD = exc_bd; EXL = 1.
//    If EXL was 1: EPC, BD and EXL are unchanged.
//    BadVAddr = exc_badva only when code is 4 or 5.
//    flush=1, flush_pc=EXC_VEC in the following cycle.
//  ERET with no take: EXL=0; flush=1; flush_pc = EPC value before the edge.
//  Simultaneous events:
//    Exception or interrupt and ERET in the same cycle: exception wins; ERET ignored.
//    mtc0 and a take in the same cycle: exception fields win; other fields take cp0_wdata.
//  Cause.IP[NUM_HW+1:2] is sampled from hw_int every cycle and is read-only.
//  Writable fields:
//    Cause: IP[1:0] only.
//    Status: IM[7:0], EXL, IE.
//    EPC: all 32 bits.
//    BadVAddr: read-only.
//  flush is a single-cycle pulse. Back-to-back takes produce back-to-back pulses.
//  Latency: event in cycle n -> registers updated at edge n -> flush high during n+1.
//  Reset mid-flush: flush clears at that edge.
// CONFIGURATION
//  CP0_TIMER_EN defined:
//    Count (reg 9) increments every second cycle using an internal toggle; wraps at 2^32.
//    Compare is reg 11.
//    Cause.TI sets when Count==Compare and clears on an mtc0 write to Compare.
//    Cause.IP[7] = hw_int[5] | TI.
//    Count and Compare are writable; mtc0 to Count also resets the toggle.
//  CP0_TIMER_EN not defined:
//    Regs 9 and 11 read 0; TI is always 0; IP[7] = hw_int[5].
// STRUCTURE
//  Shared package cp0_pkg:
//    CP0 register numbers (8, 9, 11, 12, 13, 14).
//    ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12).
//    Status/Cause field bit positions.
//  Sub-module cp0_timer: Count/Compare/TI; instantiated only under CP0_TIMER_EN.
// TESTING
//  exc_req=8'b0000_0100, code[2]=12, pc=32'h0040_0010, bd=0
//    -> EPC=0040_0010, ExcCode=12, EXL=1, flush=1 with flush_pc=BFC0_0380 in the next cycle.
//  exc_req bits 1 and 5 set together, bd=1, pc=32'h0040_0020
//    -> source 1 code taken, EPC=0040_001C, BD=1.
//  IE=1, IM[2]=1, hw_int[0]=1 together with exc_req[0]=1
//    -> ExcCode=0 (interrupt wins); with EXL=1 instead -> no interrupt taken.
//  EPC=32'h0040_0100, EXL=1, eret=1
//    -> EXL=0, flush_pc=0040_0100; eret asserted with exc_req[0]=1 -> exception vector instead.
//  Code 4 with badva=32'h0000_0003 -> BadVAddr=3; code 12 -> BadVAddr unchanged.
//  CP0_TIMER_EN: Compare=10, Count=0
//    -> TI set 20 cycles later; mtc0 to Compare clears TI; reset mid-count -> Count=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes and Status/Cause bit positions.
package cp0_pkg;

    // CP0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status field positions
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_BEV   = 22;

    // Cause field positions
    localparam int CA_CODE_LO = 2;
    localparam int CA_IP_LO   = 8;
    localparam int CA_TI      = 30;
    localparam int CA_BD      = 31;

    // Address-error exceptions are the only ones that capture BadVAddr
    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI latches on match
// and is cleared by writing Compare. Used only when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic        toggle_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        ti_reg;
    logic [31:0] count_next;

    // Next Count value: software write wins, otherwise advance on odd phase
    always_comb begin
        count_next = count_reg;
        if (count_we)
            count_next = wdata;
        else if (toggle_reg)
            count_next = count_reg + 32'd1;
    end

    // Timer state; match is checked against the value Count takes at this edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            toggle_reg  <= 1'b0;
            count_reg   <= '0;
            compare_reg <= '0;
            ti_reg      <= 1'b0;
        end else begin
            count_reg  <= count_next;
            toggle_reg <= count_we ? 1'b0 : ~toggle_reg;
            if (compare_we) begin
                compare_reg <= wdata;
                ti_reg      <= 1'b0;
            end else if (count_next == compare_reg) begin
                ti_reg <= 1'b1;
            end
        end
    end

    assign count   = count_reg;
    assign compare = compare_reg;
    assign ti      = ti_reg;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: Status, Cause, EPC, BadVAddr, exception priority,
// ERET and one-cycle flush with redirect PC.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter int          NUM_EXC = 8,
    parameter int          NUM_HW  = 6,
    parameter logic [31:0] EXC_VEC = 32'hBFC00380
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_EXC-1:0]   exc_req,
    input  logic [5*NUM_EXC-1:0] exc_code,
    input  logic [31:0]          exc_pc,
    input  logic                 exc_bd,
    input  logic [31:0]          exc_badva,
    input  logic [NUM_HW-1:0]    hw_int,
    input  logic                 eret,
    input  logic                 mtc0_we,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    output logic                 flush,
    output logic [31:0]          flush_pc,
    output logic                 exl
);

    logic [7:0]  status_im_reg;
    logic        status_exl_reg;
    logic        status_ie_reg;
    logic [7:0]  cause_ip_reg;
    logic [4:0]  cause_code_reg;
    logic        cause_bd_reg;
    logic [31:0] epc_reg;
    logic [31:0] badva_reg;
    logic        flush_reg;
    logic [31:0] flush_pc_reg;

    logic [5:0]  hw_ext;
    logic [5:0]  ip_hw_next;
    logic [4:0]  sel_code;
    logic        int_take;
    logic        exc_any;
    logic        take;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        timer_ti;

    // Map the external interrupt lines onto the six hardware IP slots
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_hw
            if (gi < NUM_HW) begin : g_used
                assign hw_ext[gi] = hw_int[gi];
            end else begin : g_unused
                assign hw_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign ip_hw_next = hw_ext | {timer_ti, 5'b0};

    assign wr_status = mtc0_we && (cp0_addr == CP0_STATUS);
    assign wr_cause  = mtc0_we && (cp0_addr == CP0_CAUSE);
    assign wr_epc    = mtc0_we && (cp0_addr == CP0_EPC);

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0_we && (cp0_addr == CP0_COUNT)),
        .compare_we (mtc0_we && (cp0_addr == CP0_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count_val),
        .compare    (compare_val),
        .ti         (timer_ti)
    );
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign timer_ti    = 1'b0;
`endif

    // Lowest-index pending source wins: scan high to low so the last hit sticks
    always_comb begin
        sel_code = EXC_INT;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_req[i])
                sel_code = exc_code[5*i +: 5];
        end
    end

    assign int_take = status_ie_reg & ~status_exl_reg & (|(cause_ip_reg & status_im_reg));
    assign exc_any  = |exc_req;
    assign take     = int_take | exc_any;

    // CP0 state: software writes first, then exception/ERET updates override them
    always_ff @(posedge clk) begin
        if (!reset) begin
            status_im_reg  <= '0;
            status_exl_reg <= 1'b0;
            status_ie_reg  <= 1'b0;
            cause_ip_reg   <= '0;
            cause_code_reg <= '0;
            cause_bd_reg   <= 1'b0;
            epc_reg        <= '0;
            badva_reg      <= '0;
            flush_reg      <= 1'b0;
            flush_pc_reg   <= '0;
        end else begin
            cause_ip_reg[7:2] <= ip_hw_next;
            if (wr_cause)
                cause_ip_reg[1:0] <= cp0_wdata[CA_IP_LO +: 2];
            if (wr_status) begin
                status_im_reg  <= cp0_wdata[ST_IM_LO +: 8];
                status_exl_reg <= cp0_wdata[ST_EXL];
                status_ie_reg  <= cp0_wdata[ST_IE];
            end
            if (wr_epc)
                epc_reg <= cp0_wdata;

            flush_reg <= 1'b0;
            if (take) begin
                cause_code_reg <= int_take ? EXC_INT : sel_code;
                if (!status_exl_reg) begin
                    epc_reg      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
                    cause_bd_reg <= exc_bd;
                end
                status_exl_reg <= 1'b1;
                if (!int_take && is_addr_exc(sel_code))
                    badva_reg <= exc_badva;
                flush_reg    <= 1'b1;
                flush_pc_reg <= EXC_VEC;
            end else if (eret) begin
                status_exl_reg <= 1'b0;
                flush_reg      <= 1'b1;
                flush_pc_reg   <= epc_reg;
            end
        end
    end

    // Assemble architectural Status and Cause views
    always_comb begin
        status_val                     = '0;
        status_val[ST_BEV]             = 1'b1;
        status_val[ST_IM_LO +: 8]      = status_im_reg;
        status_val[ST_EXL]             = status_exl_reg;
        status_val[ST_IE]              = status_ie_reg;
        cause_val                      = '0;
        cause_val[CA_BD]               = cause_bd_reg;
        cause_val[CA_TI]               = timer_ti;
        cause_val[CA_IP_LO +: 8]       = cause_ip_reg;
        cause_val[CA_CODE_LO +: 5]     = cause_code_reg;
    end

    // mfc0 read mux; unimplemented registers read zero
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_BADVADDR: cp0_rdata = badva_reg;
            CP0_COUNT:    cp0_rdata = count_val;
            CP0_COMPARE:  cp0_rdata = compare_val;
            CP0_STATUS:   cp0_rdata = status_val;
            CP0_CAUSE:    cp0_rdata = cause_val;
            CP0_EPC:      cp0_rdata = epc_reg;
            default:      cp0_rdata = '0;
        endcase
    end

    assign flush    = flush_reg;
    assign flush_pc = flush_pc_reg;
    assign exl      = status_exl_reg;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed testbench for cp0_exc_unit; timer checks compiled in with CP0_TIMER_EN.
module tb_cp0_exc_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  exc_req;
    logic [39:0] exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badva;
    logic [5:0]  hw_int;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        exl;

    int n_cmp = 0;
    int n_bad = 0;

    // Cause bits that depend on the optional timer (TI, IP[7]) are ignored
    localparam logic [31:0] CMASK = 32'hBFFF_7FFF;
    localparam logic [31:0] VEC   = 32'hBFC0_0380;

    cp0_exc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .exc_req   (exc_req),
        .exc_code  (exc_code),
        .exc_pc    (exc_pc),
        .exc_bd    (exc_bd),
        .exc_badva (exc_badva),
        .hw_int    (hw_int),
        .eret      (eret),
        .mtc0_we   (mtc0_we),
        .cp0_addr  (cp0_addr),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .exl       (exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [4:0] a);
        cp0_addr = a;
        #1;
    endtask

    task automatic write_cp0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we   = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
        step();
        mtc0_we   = 1'b0;
    endtask

    task automatic idle_inputs();
        exc_req   = '0;
        exc_code  = '0;
        exc_pc    = '0;
        exc_bd    = 1'b0;
        exc_badva = '0;
        eret      = 1'b0;
        mtc0_we   = 1'b0;
        cp0_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %0h want 0", flush); end
        n_cmp++; if (flush_pc !== 32'h0) begin n_bad++; $display("FAIL reset_flush_pc: got %08h want 00000000", flush_pc); end
        n_cmp++; if (exl !== 1'b0) begin n_bad++; $display("FAIL reset_exl: got %0h want 0", exl); end
        peek(5'd12);
        n_cmp++; if (cp0_rdata !== 32'h0040_0000) begin n_bad++; $display("FAIL reset_status: got %08h want 00400000", cp0_rdata); end
        peek(5'd13);
        n_cmp++; if ((cp0_rdata & CMASK) !== 32'h0) begin n_bad++; $display("FAIL reset_cause: got %08h want 00000000", cp0_rdata & CMASK); end
        peek(5'd14);
        n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_epc: got %08h want 00000000", cp0_rdata); end
        peek(5'd8);
        n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_badva: got %08h want 00000000", cp0_rdata); end
        $display("test_reset: done");
    endtask

    task automatic test_exc_basic();
        exc_req = 8'b0000_0100;
        exc_code[10 +: 5] = 5'd12;
        exc_pc = 32'h0040_0010;
        exc_badva = 32'h0000_1234;
        step();
        idle_inputs();
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL basic_flush: got %0h want 1", flush); end
        n_cmp++; if (flush_pc !== VEC) begin n_bad++; $display("FAIL basic_flush_pc: got %08h want %08h", flush_pc, VEC); end
        n_cmp++; if (exl !== 1'b1) begin n_bad++; $display("FAIL basic_exl: got %0h want 1", exl); end
        peek(5'd14);
        n_cmp++; if (cp0_rdata !== 32'h0040_0010) begin n_bad++; $display("FAIL basic_epc: got %08h want 00400010", cp0_rdata); end
        peek(5'd13);
        n_cmp++; if ((cp0_rdata & CMASK) !== 32'h0000_0030) begin n_bad++; $display("FAIL basic_cause: got %08h want 00000030", cp0_rdata & CMASK); end
        peek(5'd8);
        n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL basic_badva: got %08h want 00000000", cp0_rdata); end
        step();
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL basic_flush_pulse: got %0h want 0", flush); end
        write_cp0(5'd12, 32'h0);
        peek(5'd12);
        n_cmp++; if (cp0_rdata !== 32'h0040_0000) begin n_bad++; $display("FAIL basic_status_clr: got %08h want 00400000", cp0_rdata); end
        $display("test_exc_basic: done");
    endtask

    task automatic test_priority();
        exc_req = 8'b0010_0010;
        exc_code[5 +: 5]  = 5'd10;
        exc_code[25 +: 5] = 5'd8;
        exc_pc = 32'h0040_0020;
        exc_bd = 1'b1;
        step();
        idle_inputs();
        peek(5'd13);
        n_cmp++; if ((cp0_rdata & CMASK) !== 32'h8000_0028) begin n_bad++; $display("FAIL prio_cause: got %08h want 80000028", cp0_rdata & CMASK); end
        peek(5'd14);
        n_cmp++; if (cp0_rdata !== 32'h0040_001C) begin n_bad++; $display("FAIL prio_epc: got %08h want 0040001c", cp0_rdata); end
        write_cp0(5'd12, 32'h0);
        $display("test_priority: done");
    endtask

    task automatic test_badva();
        exc_req = 8'b0000_0001;
        exc_code[0 +: 5] = 5'd4;
        exc_pc = 32'h0040_0030;
        exc_badva = 32'h0000_0003;
        step();
        idle_inputs();
        peek(5'd8);
        n_cmp++; if (cp0_rdata !== 32'h0000_0003) begin n_bad++; $display("FAIL badva_capture: got %08h want 00000003", cp0_rdata); end
        peek(5'd13);
        n_cmp++; if ((cp0_rdata & CMASK) !== 32'h0000_0010) begin n_bad++; $display("FAIL badva_cause: got %08h want 00000010", cp0_rdata & CMASK); end
        write_cp0(5'd12, 32'h0);
        exc_req = 8'b0000_0001;
        exc_code[0 +: 5] = 5'd12;
        exc_badva = 32'h0000_DEAD;
        step();
        idle_inputs();
        peek(5'd8);
        n_cmp++; if (cp0_rdata !== 32'h0000_0003) begin n_bad++; $display("FAIL badva_hold: got %08h want 00000003", cp0_rdata); end
        write_cp0(5'd8, 32'hFFFF_FFFF);
        peek(5'd8);
        n_cmp++; if (cp0_rdata !== 32'h0000_0003) begin n_bad++; $display("FAIL badva_readonly: got %08h want 00000003", cp0_rdata); end
        write_cp0(5'd12, 32'h0);
        $display("test_badva: done");
    endtask

    task automatic test_interrupt();
        write_cp0(5'd12, 32'h0000_0401);
        hw_int = 6'b00_0001;
        step();
        exc_req = 8'b0000_0001;
        exc_code[0 +: 5] = 5'd12;
        exc_pc = 32'h0040_0040;
        step();
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL int_flush: got %0h want 1", flush); end
        peek(5'd13);
        n_cmp++; if ((cp0_rdata & CMASK) !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause: got %08h want 00000400", cp0_rdata & CMASK); end
        // Back-to-back take with EXL=1: interrupt masked, exception taken, EPC kept
        exc_pc = 32'h0040_0080;
        step();
        exc_req = '0;
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL b2b_flush: got %0h want 1", flush); end
        peek(5'd13);
        n_cmp++; if ((cp0_rdata & CMASK) !== 32'h0000_0430) begin n_bad++; $display("FAIL exl_masks_int_cause: got %08h want 00000430", cp0_rdata & CMASK); end
        peek(5'd14);
        n_cmp++; if (cp0_rdata !== 32'h0040_0040) begin n_bad++; $display("FAIL exl_epc_kept: got %08h want 00400040", cp0_rdata); end
        step();
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL exl_no_int: got %0h want 0", flush); end
        idle_inputs();
        hw_int = '0;
        write_cp0(5'd12, 32'h0);
        step();
        $display("test_interrupt: done");
    endtask

    task automatic test_eret();
        write_cp0(5'd14, 32'h0040_0100);
        write_cp0(5'd12, 32'h0000_0002);
        eret = 1'b1;
        step();
        eret = 1'b0;
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL eret_flush: got %0h want 1", flush); end
        n_cmp++; if (flush_pc !== 32'h0040_0100) begin n_bad++; $display("FAIL eret_flush_pc: got %08h want 00400100", flush_pc); end
        n_cmp++; if (exl !== 1'b0) begin n_bad++; $display("FAIL eret_exl: got %0h want 0", exl); end
        write_cp0(5'd12, 32'h0000_0002);
        eret = 1'b1;
        exc_req = 8'b0000_0001;
        exc_code[0 +: 5] = 5'd8;
        exc_pc = 32'h0040_0200;
        step();
        idle_inputs();
        n_cmp++; if (flush_pc !== VEC) begin n_bad++; $display("FAIL eret_vs_exc_pc: got %08h want %08h", flush_pc, VEC); end
        n_cmp++; if (exl !== 1'b1) begin n_bad++; $display("FAIL eret_vs_exc_exl: got %0h want 1", exl); end
        peek(5'd14);
        n_cmp++; if (cp0_rdata !== 32'h0040_0100) begin n_bad++; $display("FAIL eret_vs_exc_epc: got %08h want 00400100", cp0_rdata); end
        write_cp0(5'd12, 32'h0);
        $display("test_eret: done");
    endtask

    task automatic test_mtc0_take();
        mtc0_we = 1'b1;
        cp0_addr = 5'd13;
        cp0_wdata = 32'hFFFF_FFFF;
        exc_req = 8'b1000_0000;
        exc_code[35 +: 5] = 5'd9;
        exc_pc = 32'h0040_0300;
        step();
        idle_inputs();
        peek(5'd13);
        n_cmp++; if ((cp0_rdata & CMASK) !== 32'h0000_0324) begin n_bad++; $display("FAIL mtc0_take_cause: got %08h want 00000324", cp0_rdata & CMASK); end
        peek(5'd5);
        n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL unimpl_read: got %08h want 00000000", cp0_rdata); end
`ifndef CP0_TIMER_EN
        peek(5'd9);
        n_cmp++; if (cp0_rdata !== 32'h0) begin n_bad++; $display("FAIL count_absent: got %08h want 00000000", cp0_rdata); end
`endif
        write_cp0(5'd12, 32'h0);
        $display("test_mtc0_take: done");
    endtask

    task automatic test_reset_mid_flush();
        exc_req = 8'b0000_0001;
        exc_code[0 +: 5] = 5'd10;
        step();
        idle_inputs();
        n_cmp++; if (flush !== 1'b1) begin n_bad++; $display("FAIL rmf_pre_flush: got %0h want 1", flush); end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++; $display("FAIL rmf_flush: got %0h want 0", flush); end
        n_cmp++; if (exl !== 1'b0) begin n_bad++; $display("FAIL rmf_exl: got %0h want 0", exl); end
        $display("test_reset_mid_flush: done");
    endtask

`ifdef CP0_TIMER_EN
    task automatic test_timer();
        write_cp0(5'd11, 32'd10);
        write_cp0(5'd9, 32'd0);
        for (int i = 0; i < 19; i++) step();
        peek(5'd13);
        n_cmp++; if (cp0_rdata[30] !== 1'b0) begin n_bad++; $display("FAIL timer_ti_early: got %0h want 0", cp0_rdata[30]); end
        step();
        peek(5'd13);
        n_cmp++; if (cp0_rdata[30] !== 1'b1) begin n_bad++; $display("FAIL timer_ti_set: got %0h want 1", cp0_rdata[30]); end
        peek(5'd9);
        n_cmp++; if (cp0_rdata !== 32'd10) begin n_bad++; $display("FAIL timer_count: got %0d want 10", cp0_rdata); end
        write_cp0(5'd11, 32'd100);
        peek(5'd13);
        n_cmp++; if (cp0_rdata[30] !== 1'b0) begin n_bad++; $display("FAIL timer_ti_clr: got %0h want 0", cp0_rdata[30]); end
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        peek(5'd9);
        n_cmp++; if (cp0_rdata !== 32'd0) begin n_bad++; $display("FAIL timer_reset_count: got %0d want 0", cp0_rdata); end
        $display("test_timer: done");
    endtask
`endif

    initial begin
        idle_inputs();
        hw_int   = '0;
        cp0_addr = '0;
        reset    = 1'b0;
        test_reset();
        test_exc_basic();
        test_priority();
        test_badva();
        test_interrupt();
        test_eret();
        test_mtc0_take();
        test_reset_mid_flush();
`ifdef CP0_TIMER_EN
        test_timer();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
